instruction_fetch_unit: RTL and testbench

//  Upstream stage of the control_unit. Holds the PC and fetches one 32-bit word per

---
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: holds the PC, fetches one word per instruction over req/ack, computes next PC
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] count;
  logic [31:0] fetch_pc, next_pc;
  assign imem_addr = fetch_pc;
  assign opcode = instr[31:26];
  assign pc_plus4 = pc_out + 32'd4;
  // successor of the presented instruction; jump outranks a taken branch
  always_comb
    next_pc = jump ? {pc_plus4[31:28], jump_index, 2'b00}
            : branch_taken ? pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}
            : pc_plus4;
  // fetch FSM: one request outstanding, next fetch only after decode consumes
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
      pc_out <= RESET_PC;
      fetch_err <= 1'b0;
      count <= '0;
    end else
      case (state)
        IDLE: begin
          state <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH:
          if (imem_ack) begin
            instr <= imem_rdata;
            pc_out <= fetch_pc;
            instr_valid <= 1'b1;
            imem_req <= 1'b0;
            count <= '0;
            state <= VALID;
          end else if (count == LAST) begin
            imem_req <= 1'b0;
            fetch_err <= 1'b1;
            count <= '0;
            state <= ERROR;
          end else
            count <= count + 1'b1;
        VALID:
          if (!stall) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state <= ERROR;
            end else begin
              fetch_pc <= next_pc;
              imem_req <= 1'b1;
              state <= FETCH;
            end
          end
        ERROR: begin
          imem_req <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of fetch, next-PC, stall, timeout and reset behaviour
module tb_instruction_fetch_unit;
  logic clk = 1'b0, rst_n;
  logic imem_req, imem_ack, stall, jump, branch_taken, instr_valid, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4;
  logic [25:0] jump_index;
  logic [15:0] branch_offset;
  logic [5:0] opcode;
  int checks = 0, errors = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .jump_index(jump_index), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ack_word(input logic [31:0] w);
    chk("req_before_ack", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hx;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; jump = 1'b0;
    jump_index = '0; branch_taken = 1'b0; branch_offset = '0;
    step(); step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    ack_word(32'h0800_0005);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_opcode", 32'(opcode), 32'h2);
    chk("t1_instr", instr, 32'h0800_0005);
    chk("t1_pc_out", pc_out, 32'h0);
    chk("t1_pc_plus4", pc_plus4, 32'h4);
    chk("t1_req_low", 32'(imem_req), 32'd0);
    step();
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t1_next_req", 32'(imem_req), 32'd1);
    chk("t1_valid_drop", 32'(instr_valid), 32'd0);
    ack_word(32'h0800_0040);
    chk("jmp_pc_out", pc_out, 32'h4);
    jump = 1'b1; jump_index = 26'h40;
    step();
    jump = 1'b0;
    chk("jmp_addr", imem_addr, 32'h100);
    step(); step(); step();
    chk("slow_mem_req_held", 32'(imem_req), 32'd1);
    ack_word(32'h1000_0000);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jump = i[0]; jump_index = 26'h3;
      step();
    end
    chk("stall_pc_out", pc_out, 32'h100);
    chk("stall_instr", instr, 32'h1000_0000);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b1; branch_offset = 16'hFFFC;
    step();
    branch_taken = 1'b0;
    chk("br_addr", imem_addr, 32'h0F4);
    chk("br_req", 32'(imem_req), 32'd1);
    step();
    chk("br_req_held", 32'(imem_req), 32'd1);
    chk("br_addr_held", imem_addr, 32'h0F4);
    ack_word(32'h0);
    chk("br_pc_out", pc_out, 32'h0F4);
    jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h40; branch_offset = 16'hFFFC;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    chk("jmp_wins_addr", imem_addr, 32'h100);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rst_mid_instr", instr, 32'h0);
    chk("rst_mid_req", 32'(imem_req), 32'd0);
    chk("rst_mid_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    ack_word(32'h1000_FFFE);
    chk("wrap_pc0", pc_out, 32'h0);
    branch_taken = 1'b1; branch_offset = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    chk("neg_br_addr", imem_addr, 32'hFFFF_FFFC);
    ack_word(32'h0);
    chk("top_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("top_pc_plus4", pc_plus4, 32'h0);
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_err", 32'(fetch_err), 32'd0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    repeat (15) step();
    chk("to_err_early", 32'(fetch_err), 32'd0);
    chk("to_req_early", 32'(imem_req), 32'd1);
    step();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    chk("to_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step(); step();
    imem_ack = 1'b0;
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_no_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("err_cleared", 32'(fetch_err), 32'd0);
    chk("err_rst_req", 32'(imem_req), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
